// File: rtl/cache_mem_responder_if.sv
// Request/response bus between a cache controller (master) and cache_mem_responder (slave).
// Signal names carry the responder's direction suffixes so existing hookups stay familiar.
interface cache_mem_responder_if #(
  parameter int unsigned LINE_W = 128
);
  logic              mem_valid_i;
  logic              mem_we_i;
  logic [31:0]       mem_addr_i;
  logic [LINE_W-1:0] mem_wdata_i;
  logic              mem_ready_o;
  logic [LINE_W-1:0] mem_rdata_o;

  modport master (
    output mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
    input  mem_ready_o, mem_rdata_o
  );

  modport slave (
    input  mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i,
    output mem_ready_o, mem_rdata_o
  );
endinterface

// File: rtl/cache_mem_responder.sv
// Line-wide backing store answering one cache refill/writeback at a time after a fixed latency.
// Optional read/write counters are enabled with `define CACHE_MEM_STATS_EN.
module cache_mem_responder #(
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  cache_mem_responder_if.slave  mem,
  output logic                  busy_o
`ifdef CACHE_MEM_STATS_EN
  ,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o
`endif
);

  localparam int unsigned OFF_W = $clog2(LINE_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    DONE
  } state_e;

  state_e              state_q;
  logic [7:0]          cnt_q;
  logic                we_q;
  logic [IDX_W-1:0]    idx_q;
  logic [LINE_W-1:0]   wdata_q;
  logic [LINE_W-1:0]   rdata_q;
  logic                ready_q;
  logic [LINE_W-1:0]   store_q [DEPTH];

  // Ready and read data are loaded on the edge entering RESP so both are valid during RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem.mem_valid_i) begin
            we_q    <= mem.mem_we_i;
            idx_q   <= mem.mem_addr_i[OFF_W +: IDX_W];
            wdata_q <= mem.mem_wdata_i;
            cnt_q   <= 8'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
            ready_q <= 1'b1;
            if (!we_q) rdata_q <= store_q[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP:    state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write commits on the edge leaving RESP; an earlier reset forces IDLE and drops it.
  always_ff @(posedge clk_i) begin
    if (state_q == RESP && we_q) store_q[idx_q] <= wdata_q;
  end

  assign mem.mem_ready_o = ready_q;
  assign mem.mem_rdata_o = rdata_q;
  assign busy_o          = (state_q != IDLE);

`ifdef CACHE_MEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (state_q == RESP) begin
      if (we_q) begin
        if (wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
      end else begin
        if (rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      end
    end
  end

  assign rd_cnt_o = rd_cnt_q;
  assign wr_cnt_o = wr_cnt_q;
`endif

endmodule
